// File: rtl/nios2_ocimem_pkg.sv
// Shared FSM encoding, jdo field positions and RAM word format for the OCI debug-memory monitor.
// Define NIOS2_OCIMEM_PARITY_EN to store an even-parity bit per byte (36-bit RAM words).
package nios2_ocimem_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_JRD  = 3'd1,
        ST_JWR  = 3'd2,
        ST_CRD  = 3'd3,
        ST_CWR  = 3'd4
    } state_t;

    localparam int JDO_W         = 38;
    localparam int JDO_RD_BIT    = 17;
    localparam int JDO_ADDR_LSB  = 18;
    localparam int JDO_WDATA_LSB = 3;
    localparam int DATA_W        = 32;

`ifdef NIOS2_OCIMEM_PARITY_EN
    localparam int RAM_W = 36;
`else
    localparam int RAM_W = 32;
`endif
    localparam int LANE_W = RAM_W / 4;

    // Each byte lane holds {parity, byte} when parity is enabled, otherwise just the byte.
    function automatic logic [RAM_W-1:0] pack_word(input logic [DATA_W-1:0] data);
        logic [RAM_W-1:0] word;
        word = '0;
        for (int i = 0; i < 4; i++) begin
            word[i*LANE_W +: 8] = data[i*8 +: 8];
`ifdef NIOS2_OCIMEM_PARITY_EN
            word[i*LANE_W + 8] = ^data[i*8 +: 8];
`endif
        end
        return word;
    endfunction

    function automatic logic [DATA_W-1:0] unpack_word(input logic [RAM_W-1:0] word);
        logic [DATA_W-1:0] data;
        data = '0;
        for (int i = 0; i < 4; i++) begin
            data[i*8 +: 8] = word[i*LANE_W +: 8];
        end
        return data;
    endfunction

`ifdef NIOS2_OCIMEM_PARITY_EN
    function automatic logic parity_ok(input logic [RAM_W-1:0] word);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (^word[i*LANE_W +: 9]) begin
                ok = 1'b0;
            end
        end
        return ok;
    endfunction
`endif

endpackage

// File: rtl/nios2_cpu_ocimem_ram.sv
// Single-port synchronous debug RAM with per-lane write enables and a registered read port.
// Lane width follows the package word format (8 or 9 bits with NIOS2_OCIMEM_PARITY_EN).
module nios2_cpu_ocimem_ram #(
    parameter int ADDR_W = 8,
    parameter int WORD_W = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] addr,
    input  logic              we,
    input  logic [3:0]        be,
    input  logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] rdata
);

    localparam int LANE_W = WORD_W / 4;

    logic [WORD_W-1:0] mem [2**ADDR_W];
    logic [WORD_W-1:0] rdata_d;
    logic [WORD_W-1:0] rdata_q;

    // Storage is deliberately never reset; only the output register is.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem[addr][i*LANE_W +: LANE_W] <= wdata[i*LANE_W +: LANE_W];
                end
            end
        end
    end

    always_comb begin
        rdata_d = mem[addr];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/nios2_cpu_ocimem_monitor.sv
// OCI debug-memory monitor: arbitrates JTAG monitor commands and a CPU Avalon-MM slave onto one RAM.
// Define NIOS2_OCIMEM_PARITY_EN to enable per-byte parity storage and read checking.
module nios2_cpu_ocimem_monitor
    import nios2_ocimem_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [JDO_W-1:0]  jdo,
    input  logic              take_action_ocimem_a,
    input  logic              take_action_ocimem_b,
    input  logic              take_no_action_ocimem_a,
    input  logic              debugack,
    output logic [31:0]       MonDReg,
    output logic              monitor_ready,
    output logic              monitor_error,
    input  logic [ADDR_W-1:0] address,
    input  logic              read,
    input  logic              write,
    input  logic [31:0]       writedata,
    input  logic [3:0]        byteenable,
    output logic [31:0]       readdata,
    output logic              waitrequest
);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] mon_a_q, mon_a_d;
    logic [31:0]       mon_d_q, mon_d_d;
    logic              ready_q, ready_d;
    logic              error_q, error_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [RAM_W-1:0]  wr_data_q, wr_data_d;
    logic [3:0]        wr_be_q, wr_be_d;

    logic              jtag_any, cpu_wr, cpu_rd, cpu_done, rd_par_err;
    logic [ADDR_W-1:0] jdo_addr, ram_addr;
    logic              ram_we;
    logic [3:0]        ram_be;
    logic [RAM_W-1:0]  ram_wdata, ram_rdata;
    logic [31:0]       rd_data;
    logic              unused_jdo;

    assign jtag_any   = take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a;
    assign jdo_addr   = jdo[JDO_ADDR_LSB +: ADDR_W];
    assign unused_jdo = ^{jdo[JDO_W-1:JDO_WDATA_LSB+DATA_W], jdo[JDO_WDATA_LSB-1:0]};
    assign rd_data    = unpack_word(ram_rdata);
    assign cpu_wr     = write;
    assign cpu_rd     = read & ~write;

    // JTAG takes priority in IDLE, so a CPU write only completes when no strobe is present.
    assign cpu_done    = ((state_q == ST_IDLE) && !jtag_any && cpu_wr) ||
                         ((state_q == ST_CRD) && cpu_rd);
    assign waitrequest = (read | write) & ~cpu_done;

`ifdef NIOS2_OCIMEM_PARITY_EN
    assign rd_par_err = ~parity_ok(ram_rdata);
`else
    assign rd_par_err = 1'b0;
`endif

    always_comb begin
        ram_addr  = address;
        ram_we    = 1'b0;
        ram_be    = wr_be_q;
        ram_wdata = wr_data_q;
        case (state_q)
            ST_IDLE: begin
                if (take_action_ocimem_a) begin
                    ram_addr = jdo_addr;
                end else if (take_no_action_ocimem_a) begin
                    ram_addr = mon_a_q;
                end
            end
            ST_JWR, ST_CWR: begin
                ram_addr = wr_addr_q;
                ram_we   = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        mon_a_d   = mon_a_q;
        mon_d_d   = mon_d_q;
        ready_d   = ready_q;
        error_d   = error_q;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        wr_be_d   = wr_be_q;
        case (state_q)
            ST_IDLE: begin
                if (take_action_ocimem_a) begin
                    mon_a_d = jdo_addr;
                    ready_d = 1'b0;
                    error_d = 1'b0;
                    if (jdo[JDO_RD_BIT]) begin
                        state_d = ST_JRD;
                    end
                end else if (take_no_action_ocimem_a) begin
                    ready_d = 1'b0;
                    error_d = 1'b0;
                    state_d = ST_JRD;
                end else if (take_action_ocimem_b) begin
                    // A write outside debug mode is refused and reported at once.
                    if (debugack) begin
                        ready_d   = 1'b0;
                        error_d   = 1'b0;
                        wr_addr_d = mon_a_q;
                        wr_data_d = pack_word(jdo[JDO_WDATA_LSB +: DATA_W]);
                        wr_be_d   = 4'hF;
                        state_d   = ST_JWR;
                    end else begin
                        ready_d = 1'b1;
                        error_d = 1'b1;
                    end
                end else if (cpu_wr) begin
                    wr_addr_d = address;
                    wr_data_d = pack_word(writedata);
                    wr_be_d   = byteenable;
                    state_d   = ST_CWR;
                end else if (cpu_rd) begin
                    state_d = ST_CRD;
                end
            end
            ST_JRD: begin
                mon_d_d = rd_data;
                ready_d = 1'b1;
                mon_a_d = mon_a_q + 1'b1;
                if (rd_par_err) begin
                    error_d = 1'b1;
                end
                state_d = ST_IDLE;
            end
            ST_JWR: begin
                ready_d = 1'b1;
                mon_a_d = mon_a_q + 1'b1;
                state_d = ST_IDLE;
            end
            ST_CRD: begin
                if (rd_par_err) begin
                    error_d = 1'b1;
                end
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        if ((state_q != ST_IDLE) && jtag_any) begin
            error_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            mon_a_q   <= '0;
            mon_d_q   <= '0;
            ready_q   <= 1'b0;
            error_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            wr_be_q   <= '0;
        end else begin
            state_q   <= state_d;
            mon_a_q   <= mon_a_d;
            mon_d_q   <= mon_d_d;
            ready_q   <= ready_d;
            error_q   <= error_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            wr_be_q   <= wr_be_d;
        end
    end

    nios2_cpu_ocimem_ram #(
        .ADDR_W (ADDR_W),
        .WORD_W (RAM_W)
    ) u_ram (
        .clk     (clk),
        .reset_n (reset_n),
        .addr    (ram_addr),
        .we      (ram_we),
        .be      (ram_be),
        .wdata   (ram_wdata),
        .rdata   (ram_rdata)
    );

    assign MonDReg       = mon_d_q;
    assign monitor_ready = ready_q;
    assign monitor_error = error_q;
    assign readdata      = rd_data;

endmodule

// File: tb/tb_nios2_cpu_ocimem_monitor.sv
// Directed, table-driven bench for the OCI debug-memory monitor (JTAG and CPU paths).
// The parity corner case is compiled in only with NIOS2_OCIMEM_PARITY_EN.
module tb_nios2_cpu_ocimem_monitor;

    localparam int ADDR_W = 8;

    typedef enum logic [2:0] {OP_JSET, OP_JSETRD, OP_JWRITE, OP_JREAD, OP_CWRITE, OP_CREAD} op_t;

    typedef struct {
        op_t         op;
        logic [7:0]  addr;
        logic [31:0] data;
        logic [3:0]  be;
        logic        dbg;
        logic [31:0] exp_data;
        logic [7:0]  exp_mona;
        logic        exp_ready;
        logic        exp_error;
    } vec_t;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic [37:0]       jdo = '0;
    logic              take_action_ocimem_a = 1'b0;
    logic              take_action_ocimem_b = 1'b0;
    logic              take_no_action_ocimem_a = 1'b0;
    logic              debugack = 1'b1;
    logic [31:0]       MonDReg;
    logic              monitor_ready;
    logic              monitor_error;
    logic [ADDR_W-1:0] address = '0;
    logic              read = 1'b0;
    logic              write = 1'b0;
    logic [31:0]       writedata = '0;
    logic [3:0]        byteenable = '0;
    logic [31:0]       readdata;
    logic              waitrequest;

    int          checks = 0;
    int          failures = 0;
    vec_t        vecs[$];
    logic [31:0] last_rdata;
    int          last_waits;
    logic        last_wr_seen;

    nios2_cpu_ocimem_monitor #(.ADDR_W(ADDR_W)) dut (
        .clk                     (clk),
        .reset_n                 (reset_n),
        .jdo                     (jdo),
        .take_action_ocimem_a    (take_action_ocimem_a),
        .take_action_ocimem_b    (take_action_ocimem_b),
        .take_no_action_ocimem_a (take_no_action_ocimem_a),
        .debugack                (debugack),
        .MonDReg                 (MonDReg),
        .monitor_ready           (monitor_ready),
        .monitor_error           (monitor_error),
        .address                 (address),
        .read                    (read),
        .write                   (write),
        .writedata               (writedata),
        .byteenable              (byteenable),
        .readdata                (readdata),
        .waitrequest             (waitrequest)
    );

    always #5 clk = ~clk;

    task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [37:0] jdoAddr(input logic [7:0] a, input logic rd);
        logic [37:0] j;
        j = '0;
        j[25:18] = a;
        j[17] = rd;
        return j;
    endfunction

    function automatic logic [37:0] jdoData(input logic [31:0] d);
        logic [37:0] j;
        j = '0;
        j[34:3] = d;
        return j;
    endfunction

    // kind: 0 = take_action_a, 1 = take_action_b, 2 = take_no_action_a; two cycles covers every JTAG op
    task automatic jtagStrobe(input int kind, input logic [37:0] j);
        jdo = j;
        case (kind)
            0: take_action_ocimem_a = 1'b1;
            1: take_action_ocimem_b = 1'b1;
            default: take_no_action_ocimem_a = 1'b1;
        endcase
        tick();
        take_action_ocimem_a = 1'b0;
        take_action_ocimem_b = 1'b0;
        take_no_action_ocimem_a = 1'b0;
        tick();
    endtask

    task automatic cpuWrite(input logic [7:0] a, input logic [31:0] d, input logic [3:0] be);
        address = a;
        writedata = d;
        byteenable = be;
        write = 1'b1;
        #1;
        last_wr_seen = waitrequest;
        tick();
        write = 1'b0;
        tick();
    endtask

    // kind < 0: plain CPU read; otherwise a JTAG strobe of that kind is raised in the same cycle
    task automatic cpuRead(input logic [7:0] a, input int kind, input logic [37:0] j);
        address = a;
        read = 1'b1;
        jdo = j;
        if (kind == 0) take_action_ocimem_a = 1'b1;
        if (kind == 1) take_action_ocimem_b = 1'b1;
        if (kind == 2) take_no_action_ocimem_a = 1'b1;
        last_waits = 0;
        for (int i = 0; i < 8; i++) begin
            #1;
            if (!waitrequest) break;
            last_waits++;
            tick();
            take_action_ocimem_a = 1'b0;
            take_action_ocimem_b = 1'b0;
            take_no_action_ocimem_a = 1'b0;
        end
        last_rdata = readdata;
        tick();
        read = 1'b0;
    endtask

    task automatic addVec(input op_t op, input logic [7:0] addr, input logic [31:0] data,
                          input logic [3:0] be, input logic dbg, input logic [31:0] exp_data,
                          input logic [7:0] exp_mona, input logic exp_ready, input logic exp_error);
        vec_t v;
        v.op = op; v.addr = addr; v.data = data; v.be = be; v.dbg = dbg;
        v.exp_data = exp_data; v.exp_mona = exp_mona;
        v.exp_ready = exp_ready; v.exp_error = exp_error;
        vecs.push_back(v);
    endtask

    task automatic applyStimulus(input vec_t v);
        debugack = v.dbg;
        case (v.op)
            OP_JSET:   jtagStrobe(0, jdoAddr(v.addr, 1'b0));
            OP_JSETRD: jtagStrobe(0, jdoAddr(v.addr, 1'b1));
            OP_JWRITE: jtagStrobe(1, jdoData(v.data));
            OP_JREAD:  jtagStrobe(2, '0);
            OP_CWRITE: cpuWrite(v.addr, v.data, v.be);
            default:   cpuRead(v.addr, -1, '0);
        endcase
        debugack = 1'b1;
    endtask

    task automatic checkOutput(input vec_t v, input int idx);
        checkVal($sformatf("vec%0d mona", idx), 32'(dut.mon_a_q), 32'(v.exp_mona));
        checkVal($sformatf("vec%0d ready", idx), 32'(monitor_ready), 32'(v.exp_ready));
        checkVal($sformatf("vec%0d error", idx), 32'(monitor_error), 32'(v.exp_error));
        case (v.op)
            OP_JSETRD, OP_JREAD: checkVal($sformatf("vec%0d MonDReg", idx), MonDReg, v.exp_data);
            OP_CREAD: begin
                checkVal($sformatf("vec%0d readdata", idx), last_rdata, v.exp_data);
                checkVal($sformatf("vec%0d read waits", idx), 32'(last_waits), 32'd1);
            end
            OP_CWRITE: checkVal($sformatf("vec%0d write wait", idx), 32'(last_wr_seen), 32'd0);
            default: ;
        endcase
    endtask

    task automatic checkReset(input string tag);
        checkVal({tag, " mona"}, 32'(dut.mon_a_q), 32'd0);
        checkVal({tag, " MonDReg"}, MonDReg, 32'd0);
        checkVal({tag, " readdata"}, readdata, 32'd0);
        checkVal({tag, " ready"}, 32'(monitor_ready), 32'd0);
        checkVal({tag, " error"}, 32'(monitor_error), 32'd0);
        checkVal({tag, " waitrequest"}, 32'(waitrequest), 32'd0);
    endtask

    initial begin
        //      op         addr   data          be     dbg   exp_data      mona   rdy   err
        addVec(OP_JSET,   8'h00, 32'h0,        4'h0, 1'b1, 32'h0,        8'h00, 1'b0, 1'b0);
        addVec(OP_JWRITE, 8'h00, 32'hDEADBEEF, 4'h0, 1'b1, 32'h0,        8'h01, 1'b1, 1'b0);
        addVec(OP_JWRITE, 8'h00, 32'hDEADBEEF, 4'h0, 1'b1, 32'h0,        8'h02, 1'b1, 1'b0);
        addVec(OP_JSET,   8'h01, 32'h0,        4'h0, 1'b1, 32'h0,        8'h01, 1'b0, 1'b0);
        addVec(OP_JREAD,  8'h00, 32'h0,        4'h0, 1'b1, 32'hDEADBEEF, 8'h02, 1'b1, 1'b0);
        addVec(OP_JSET,   8'hFE, 32'h0,        4'h0, 1'b1, 32'h0,        8'hFE, 1'b0, 1'b0);
        addVec(OP_JWRITE, 8'h00, 32'h0BADF00D, 4'h0, 1'b1, 32'h0,        8'hFF, 1'b1, 1'b0);
        addVec(OP_JWRITE, 8'h00, 32'hCAFEBABE, 4'h0, 1'b1, 32'h0,        8'h00, 1'b1, 1'b0);
        addVec(OP_JSETRD, 8'hFF, 32'h0,        4'h0, 1'b1, 32'hCAFEBABE, 8'h00, 1'b1, 1'b0);
        addVec(OP_JREAD,  8'h00, 32'h0,        4'h0, 1'b1, 32'hDEADBEEF, 8'h01, 1'b1, 1'b0);
        addVec(OP_JWRITE, 8'h00, 32'h11111111, 4'h0, 1'b0, 32'h0,        8'h01, 1'b1, 1'b1);
        addVec(OP_JREAD,  8'h00, 32'h0,        4'h0, 1'b1, 32'hDEADBEEF, 8'h02, 1'b1, 1'b0);
        addVec(OP_CWRITE, 8'h05, 32'hFFFFFFFF, 4'hF, 1'b1, 32'h0,        8'h02, 1'b1, 1'b0);
        addVec(OP_CWRITE, 8'h05, 32'h12345678, 4'h3, 1'b1, 32'h0,        8'h02, 1'b1, 1'b0);
        addVec(OP_CREAD,  8'h05, 32'h0,        4'h0, 1'b1, 32'hFFFF5678, 8'h02, 1'b1, 1'b0);
        addVec(OP_CWRITE, 8'h07, 32'h00000000, 4'hF, 1'b1, 32'h0,        8'h02, 1'b1, 1'b0);
        addVec(OP_CWRITE, 8'h07, 32'hAABBCCDD, 4'hC, 1'b1, 32'h0,        8'h02, 1'b1, 1'b0);
        addVec(OP_CREAD,  8'h07, 32'h0,        4'h0, 1'b1, 32'hAABB0000, 8'h02, 1'b1, 1'b0);
        addVec(OP_CREAD,  8'hFE, 32'h0,        4'h0, 1'b1, 32'h0BADF00D, 8'h02, 1'b1, 1'b0);
        addVec(OP_JSETRD, 8'h05, 32'h0,        4'h0, 1'b1, 32'hFFFF5678, 8'h06, 1'b1, 1'b0);
        addVec(OP_JSETRD, 8'h07, 32'h0,        4'h0, 1'b1, 32'hAABB0000, 8'h08, 1'b1, 1'b0);

        #2;
        checkReset("reset");
        tick();
        tick();
        reset_n = 1'b1;
        tick();

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i]);
            checkOutput(vecs[i], i);
        end

        // CPU read colliding with a JTAG read: JTAG first, CPU stalled two extra cycles
        jtagStrobe(0, jdoAddr(8'h00, 1'b0));
        cpuRead(8'h05, 2, '0);
        checkVal("collide waits", 32'(last_waits), 32'd3);
        checkVal("collide readdata", last_rdata, 32'hFFFF5678);
        checkVal("collide MonDReg", MonDReg, 32'hDEADBEEF);
        checkVal("collide mona", 32'(dut.mon_a_q), 32'd1);
        checkVal("collide ready", 32'(monitor_ready), 32'd1);

        // Strobe while busy is ignored but flagged
        take_no_action_ocimem_a = 1'b1;
        tick();
        take_no_action_ocimem_a = 1'b0;
        jdo = jdoData(32'h55555555);
        take_action_ocimem_b = 1'b1;
        tick();
        take_action_ocimem_b = 1'b0;
        tick();
        checkVal("busy error", 32'(monitor_error), 32'd1);
        checkVal("busy ready", 32'(monitor_ready), 32'd1);
        checkVal("busy mona", 32'(dut.mon_a_q), 32'd2);
        jtagStrobe(0, jdoAddr(8'h01, 1'b1));
        checkVal("busy word1 intact", MonDReg, 32'hDEADBEEF);
        checkVal("busy error cleared", 32'(monitor_error), 32'd0);

        // Reset in the middle of a JTAG write must abandon it
        jtagStrobe(0, jdoAddr(8'h03, 1'b0));
        jtagStrobe(1, jdoData(32'h33333333));
        jtagStrobe(0, jdoAddr(8'h03, 1'b0));
        jdo = jdoData(32'h44444444);
        take_action_ocimem_b = 1'b1;
        tick();
        take_action_ocimem_b = 1'b0;
        reset_n = 1'b0;
        #1;
        checkReset("midreset");
        tick();
        reset_n = 1'b1;
        tick();
        jtagStrobe(0, jdoAddr(8'h03, 1'b1));
        checkVal("abandoned write", MonDReg, 32'h33333333);
        checkVal("abandoned mona", 32'(dut.mon_a_q), 32'd4);

`ifdef NIOS2_OCIMEM_PARITY_EN
        cpuWrite(8'h09, 32'h0F0F0F0F, 4'hF);
        dut.u_ram.mem[9][8] = ~dut.u_ram.mem[9][8];
        jtagStrobe(0, jdoAddr(8'h09, 1'b1));
        checkVal("parity jtag error", 32'(monitor_error), 32'd1);
        checkVal("parity jtag data", MonDReg, 32'h0F0F0F0F);
        jtagStrobe(0, jdoAddr(8'h00, 1'b0));
        checkVal("parity error cleared", 32'(monitor_error), 32'd0);
        cpuRead(8'h09, -1, '0);
        checkVal("parity cpu data", last_rdata, 32'h0F0F0F0F);
        checkVal("parity cpu error", 32'(monitor_error), 32'd1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
